// File: rtl/codificador_segmentos_pkg.sv
//------------------------------------------------------------------------------
// codificador_segmentos_pkg : segment patterns and scan FSM encoding
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package codificador_segmentos_pkg;

  // Active-low patterns, bit6 = a ... bit0 = g
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    AMOSTRA   = 2'd1,
    CAPTURADO = 2'd2
  } estado_t;

endpackage

`default_nettype wire

// File: rtl/codificador_segmentos_if.sv
//------------------------------------------------------------------------------
// codificador_segmentos_if : snooped display bus plus recovered-frame outputs
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface codificador_segmentos_if #(
  parameter int NUM_DIG = 4
);
  logic [6:0]           segmentos;
  logic [NUM_DIG-1:0]   anodos;
  logic [4*NUM_DIG-1:0] valor;
  logic [NUM_DIG-1:0]   apagado;
  logic                 erro;
  logic                 atualizado;

  modport master (
    output segmentos, anodos,
    input  valor, apagado, erro, atualizado
  );

  modport slave (
    input  segmentos, anodos,
    output valor, apagado, erro, atualizado
  );
endinterface

`default_nettype wire

// File: rtl/seg_para_hex.sv
//------------------------------------------------------------------------------
// seg_para_hex : inverse 7-segment table, pattern -> {nibble, blank, invalid}
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg_para_hex
  import codificador_segmentos_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       invalido
);

  always_comb begin
    nibble   = 4'h0;
    blank    = 1'b0;
    invalido = 1'b0;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: blank  = 1'b1;
      default:   invalido = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/codificador_segmentos.sv
//------------------------------------------------------------------------------
// codificador_segmentos : recovers hex digits from a multiplexed 7-seg bus.
// Optional input synchronizer: define CODIF_SINC_EN.          Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module codificador_segmentos
  import codificador_segmentos_pkg::*;
#(
  parameter int NUM_DIG = 4,
  parameter int ESTAVEL = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  codificador_segmentos_if.slave  bus
);

  localparam int CNT_W = $clog2(ESTAVEL + 1);
  localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  logic [NUM_DIG-1:0] w_anod;
  logic [6:0]         w_seg;

`ifdef CODIF_SINC_EN
  logic [NUM_DIG-1:0] r_anod_s1, r_anod_s2;
  logic [6:0]         r_seg_s1, r_seg_s2;

  // Idle-bus reset value so the first real selection is seen as a change
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_anod_s1 <= '1;
      r_anod_s2 <= '1;
      r_seg_s1  <= '1;
      r_seg_s2  <= '1;
    end else begin
      r_anod_s1 <= bus.anodos;
      r_anod_s2 <= r_anod_s1;
      r_seg_s1  <= bus.segmentos;
      r_seg_s2  <= r_seg_s1;
    end
  end

  assign w_anod = r_anod_s2;
  assign w_seg  = r_seg_s2;
`else
  assign w_anod = bus.anodos;
  assign w_seg  = bus.segmentos;
`endif

  logic [NUM_DIG-1:0] r_prev_anod;
  logic [6:0]         r_prev_seg;
  logic               w_mudou;
  logic [3:0]         w_zeros;
  logic [IDX_W-1:0]   w_idx;
  logic               w_valido;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prev_anod <= '1;
      r_prev_seg  <= '1;
    end else begin
      r_prev_anod <= w_anod;
      r_prev_seg  <= w_seg;
    end
  end

  assign w_mudou = (w_anod != r_prev_anod) || (w_seg != r_prev_seg);

  always_comb begin
    w_zeros = 4'd0;
    w_idx   = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (!w_anod[i]) begin
        w_zeros = w_zeros + 4'd1;
        w_idx   = IDX_W'(i);
      end
    end
  end

  assign w_valido = (w_zeros == 4'd1);

  logic [3:0] w_nib;
  logic       w_blank;
  logic       w_inv;

  seg_para_hex u_seg_para_hex (
    .seg      (w_seg),
    .nibble   (w_nib),
    .blank    (w_blank),
    .invalido (w_inv)
  );

  estado_t          r_estado, w_prox;
  logic [CNT_W-1:0] r_cnt, w_cnt_prox;
  logic             w_captura;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= OCIOSO;
      r_cnt    <= '0;
    end else begin
      r_estado <= w_prox;
      r_cnt    <= w_cnt_prox;
    end
  end

  // The sample seen on the edge that enters AMOSTRA already counts as 1
  always_comb begin
    w_prox     = r_estado;
    w_cnt_prox = r_cnt;
    w_captura  = 1'b0;
    case (r_estado)
      OCIOSO: begin
        w_cnt_prox = '0;
        if (w_valido) begin
          w_prox     = AMOSTRA;
          w_cnt_prox = CNT_W'(1);
        end
      end
      AMOSTRA: begin
        if (!w_valido) begin
          w_prox     = OCIOSO;
          w_cnt_prox = '0;
        end else if (w_mudou) begin
          w_cnt_prox = CNT_W'(1);
        end else if (r_cnt == CNT_W'(ESTAVEL - 1)) begin
          w_cnt_prox = CNT_W'(ESTAVEL);
          w_captura  = 1'b1;
          w_prox     = CAPTURADO;
        end else begin
          w_cnt_prox = r_cnt + CNT_W'(1);
        end
      end
      CAPTURADO: begin
        if (w_mudou) begin
          if (w_valido) begin
            w_prox     = AMOSTRA;
            w_cnt_prox = CNT_W'(1);
          end else begin
            w_prox     = OCIOSO;
            w_cnt_prox = '0;
          end
        end
      end
      default: begin
        w_prox     = OCIOSO;
        w_cnt_prox = '0;
      end
    endcase
  end

  logic [NUM_DIG-1:0]   r_mask;
  logic [4*NUM_DIG-1:0] r_sh_nib;
  logic [NUM_DIG-1:0]   r_sh_blank;
  logic [NUM_DIG-1:0]   r_sh_err;
  logic                 w_commit;

  assign w_commit = &r_mask;

  // A capture landing on the commit edge survives the clear and opens the next frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mask     <= '0;
      r_sh_nib   <= '0;
      r_sh_blank <= '0;
      r_sh_err   <= '0;
    end else begin
      if (w_commit) begin
        r_mask   <= '0;
        r_sh_err <= '0;
      end
      if (w_captura) begin
        r_mask[w_idx]              <= 1'b1;
        r_sh_nib[{w_idx, 2'b00} +: 4] <= w_nib;
        r_sh_blank[w_idx]          <= w_blank;
        r_sh_err[w_idx]            <= w_inv;
      end
    end
  end

  logic [4*NUM_DIG-1:0] r_valor;
  logic [NUM_DIG-1:0]   r_apagado;
  logic                 r_erro;
  logic                 r_atualizado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valor      <= '0;
      r_apagado    <= '0;
      r_erro       <= 1'b0;
      r_atualizado <= 1'b0;
    end else begin
      r_atualizado <= w_commit;
      if (w_commit) begin
        r_valor   <= r_sh_nib;
        r_apagado <= r_sh_blank;
        r_erro    <= |r_sh_err;
      end
    end
  end

  assign bus.valor      = r_valor;
  assign bus.apagado    = r_apagado;
  assign bus.erro       = r_erro;
  assign bus.atualizado = r_atualizado;

endmodule

`default_nettype wire

// File: tb/tb_codificador_segmentos.sv
//------------------------------------------------------------------------------
// tb_codificador_segmentos : frame vectors, corner sequences and random scans
// checked every cycle against a run-length reference model.      Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_codificador_segmentos;

  localparam int NUM_DIG = 4;
  localparam int ESTAVEL = 4;
`ifdef CODIF_SINC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  localparam int PW = NUM_DIG + 7;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  codificador_segmentos_if #(.NUM_DIG(NUM_DIG)) bus ();

  codificador_segmentos #(
    .NUM_DIG (NUM_DIG),
    .ESTAVEL (ESTAVEL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [6:0] pat [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_pulse  = 0;
  int pulse_cyc = 0;
  int start_cyc = 0;

  // Reference model: a digit is taken once its (delayed) pin pair has been seen
  // ESTAVEL times in a row; a frame is published the edge after all are taken.
  logic [PW-1:0]        m_q [$];
  logic [PW-1:0]        m_prev;
  int                   m_run;
  logic [NUM_DIG-1:0]   m_mask;
  logic [3:0]           m_nib   [NUM_DIG];
  logic                 m_blank [NUM_DIG];
  logic                 m_err   [NUM_DIG];
  logic [4*NUM_DIG-1:0] m_valor;
  logic [NUM_DIG-1:0]   m_apag;
  logic                 m_erro;
  logic                 m_atual;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < S; i++) m_q.push_back('1);
    m_prev  = '1;
    m_run   = 0;
    m_mask  = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      m_nib[i] = 4'h0; m_blank[i] = 1'b0; m_err[i] = 1'b0;
    end
    m_valor = '0; m_apag = '0; m_erro = 1'b0; m_atual = 1'b0;
  endtask

  task automatic decode(input logic [6:0] s, output logic [3:0] n,
                        output logic bl, output logic er);
    n  = 4'h0;
    bl = (s == 7'b1111111);
    er = !bl;
    for (int i = 0; i < 16; i++)
      if (pat[i] == s) begin n = 4'(i); er = 1'b0; end
  endtask

  task automatic model_step();
    logic [PW-1:0] pins, pair;
    int zeros, d;
    logic [3:0] nb;
    logic bl, er;
    pins = {bus.anodos, bus.segmentos};
    if (S > 0) begin
      m_q.push_back(pins);
      pair = m_q.pop_front();
    end else begin
      pair = pins;
    end
    m_run  = (pair == m_prev) ? m_run + 1 : 1;
    m_prev = pair;
    zeros = 0; d = 0;
    for (int i = 0; i < NUM_DIG; i++)
      if (!pair[7+i]) begin zeros++; d = i; end
    m_atual = (m_mask == '1);
    if (m_atual) begin
      m_erro = 1'b0;
      for (int i = 0; i < NUM_DIG; i++) begin
        m_valor[4*i +: 4] = m_nib[i];
        m_apag[i] = m_blank[i];
        m_erro = m_erro | m_err[i];
        m_err[i] = 1'b0;
      end
      m_mask = '0;
    end
    if (zeros == 1 && m_run == ESTAVEL) begin
      decode(pair[6:0], nb, bl, er);
      m_nib[d] = nb; m_blank[d] = bl; m_err[d] = er;
      m_mask[d] = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    n_checks++;
    if ({bus.valor, bus.apagado, bus.erro, bus.atualizado} !==
        {m_valor, m_apag, m_erro, m_atual}) begin
      n_fail++;
      $display("FAIL model cycle %0d: got valor=%h apagado=%b erro=%b atualizado=%b, expected valor=%h apagado=%b erro=%b atualizado=%b",
               cyc, bus.valor, bus.apagado, bus.erro, bus.atualizado,
               m_valor, m_apag, m_erro, m_atual);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    cyc++;
    @(negedge clock);
    check_model();
    if (bus.atualizado === 1'b1) begin
      n_pulse++;
      pulse_cyc = cyc;
    end
  endtask

  task automatic hold(input logic [NUM_DIG-1:0] an, input logic [6:0] sg, input int n);
    bus.anodos    = an;
    bus.segmentos = sg;
    repeat (n) tick();
  endtask

  function automatic logic [NUM_DIG-1:0] sel(input int d);
    logic [NUM_DIG-1:0] one;
    one = NUM_DIG'(1) << d;
    return ~one;
  endfunction

  task automatic scan(input logic [27:0] segs, input int n);
    for (int d = NUM_DIG - 1; d >= 0; d--) begin
      if (d == 0) start_cyc = cyc + 1;
      hold(sel(d), segs[7*d +: 7], n);
    end
  endtask

  typedef struct {
    logic [27:0] segs;
    logic [15:0] valor;
    logic [3:0]  apagado;
    logic        erro;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{{7'b0010010, 7'b0000001, 7'b0010010, 7'b1001100}, 16'h2024, 4'b0000, 1'b0};
    vecs[1] = '{{7'b0001000, 7'b1100000, 7'b0110110, 7'b0111000}, 16'hAB0F, 4'b0000, 1'b1};
    vecs[2] = '{{7'b0110001, 7'b1000010, 7'b0110000, 7'b1001111}, 16'hCDE1, 4'b0000, 1'b0};
    vecs[3] = '{{7'b0001111, 7'b1111111, 7'b0000000, 7'b0000100}, 16'h7089, 4'b0100, 1'b0};
    vecs[4] = '{{7'b0000110, 7'b0100100, 7'b0100000, 7'b0000001}, 16'h3560, 4'b0000, 1'b0};

    bus.anodos    = '1;
    bus.segmentos = '1;
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("reset_outputs", {bus.valor, bus.apagado, bus.erro, bus.atualizado}, 32'h0);
    reset = 1'b1;

    for (int v = 0; v < 5; v++) begin
      n_pulse = 0;
      scan(vecs[v].segs, 8);
      chk("frame_pulses", n_pulse, 1);
      chk("frame_valor", bus.valor, vecs[v].valor);
      chk("frame_apagado", bus.apagado, vecs[v].apagado);
      chk("frame_erro", bus.erro, vecs[v].erro);
      chk("frame_latency", pulse_cyc - start_cyc, S + ESTAVEL);
    end

    // Segments toggling every 3 cycles never reach ESTAVEL samples
    n_pulse = 0;
    for (int i = 0; i < 8; i++) hold(sel(3), (i % 2 == 0) ? pat[5] : pat[6], 3);
    hold(sel(2), pat[1], 8);
    hold(sel(1), pat[2], 8);
    hold(sel(0), pat[3], 8);
    chk("glitch_no_pulse", n_pulse, 0);
    hold(sel(3), pat[9], S + ESTAVEL + 1);
    chk("glitch_then_stable_pulse", n_pulse, 1);
    chk("glitch_then_stable_valor", bus.valor, 16'h9123);

    n_pulse = 0;
    hold(4'b0000, pat[8], 20);
    hold(4'b1111, pat[8], 20);
    chk("idle_no_pulse", n_pulse, 0);
    chk("idle_valor_held", bus.valor, 16'h9123);

    // Reset with three digits already in the shadow
    n_pulse = 0;
    hold(sel(3), pat[4], 8);
    hold(sel(2), pat[5], 8);
    hold(sel(1), pat[6], 8);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midframe_reset_outputs", {bus.valor, bus.apagado, bus.erro, bus.atualizado}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    hold(sel(0), pat[7], 8);
    chk("after_reset_partial_no_pulse", n_pulse, 0);
    chk("after_reset_partial_valor", bus.valor, 16'h0000);
    scan({pat[4], pat[5], pat[6], pat[7]}, 8);
    chk("after_reset_full_pulse", n_pulse, 1);
    chk("after_reset_full_valor", bus.valor, 16'h4567);

    for (int i = 0; i < 80; i++) begin
      logic [NUM_DIG-1:0] an;
      logic [6:0] sg;
      int r;
      r  = $urandom_range(0, 9);
      an = (r == 0) ? NUM_DIG'($urandom_range(0, 15)) : sel($urandom_range(0, NUM_DIG - 1));
      r  = $urandom_range(0, 7);
      if (r < 6)       sg = pat[$urandom_range(0, 15)];
      else if (r == 6) sg = 7'b1111111;
      else             sg = 7'($urandom_range(0, 127));
      hold(an, sg, $urandom_range(1, 9));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/codificador_segmentos.md
# codificador_segmentos

Reverse of the hex-to-7-segment decoder: it snoops a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode selects) and recovers the hex value shown on each digit. Each pattern must be stable before it is captured. A complete frame is published as one word, with a one-cycle update strobe, a blank mask and an invalid-pattern flag. It sits on the FPGA board-test path, so the display output of the RISC-V core can be checked in hardware without a camera.

## Interface
- NUM_DIG, 4: number of multiplexed digits (1–8).
- ESTAVEL, 4: consecutive identical samples required before a digit is captured (≥2).
- clock  in  1  single system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- segmentos  in  7  active-low segment lines; bit6=a … bit0=g.
- anodos  in  NUM_DIG  active-low digit selects; exactly one low = valid selection.
- valor  out  4*NUM_DIG  recovered nibbles; digit d in bits [4d+3:4d]; reset 0.
- apagado  out  NUM_DIG  digit d showed 7'b1111111 (blank); reset 0.
- erro  out  1  at least one digit in the last frame had an unknown pattern; reset 0.
- atualizado  out  1  one-cycle pulse when valor/apagado/erro take new values; reset 0.

## Operation
- Pattern table (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, B=1100000
  - C=0110001, D=1000010, E=0110000, F=0111000
  - 1111111 = blank (nibble 0, apagado bit set).
  - Any other pattern = invalid (nibble 0, error bit set).
- Sampled pair: (anodos, segmentos) after the optional synchronizer. The pair is compared each cycle with the previous sampled pair.
- FSM per scan, with states OCIOSO, AMOSTRA, CAPTURADO:
  - OCIOSO: anodos not one-hot-low (none or several digits selected). Counter held at 0. Go to AMOSTRA when a valid selection appears.
  - AMOSTRA: counter increments while the pair is unchanged and restarts at 1 on any change.
    - At counter = ESTAVEL, decode the digit into its shadow slot, set captured mask bit d, and go to CAPTURADO.
    - A non-one-hot selection returns the FSM to OCIOSO.
  - CAPTURADO: ignore the held pair. On any change go to AMOSTRA with counter = 1, or to OCIOSO if the new selection is invalid.
- Shadow slots: each captured digit has a nibble, a blank bit and an error bit.
- Recapture: capturing the same digit again before the frame completes overwrites its shadow slot.
- Frame commit: the cycle after the captured mask becomes all ones:
  - shadow is copied to valor/apagado;
  - erro = OR of the shadow error bits;
  - atualizado = 1 for one cycle;
  - captured mask and shadow error bits are cleared.
- Outputs hold between commits.
- Reset mid-frame: all state, shadow and outputs go to 0 immediately (asynchronous). After reset release the first commit requires all NUM_DIG digits to be recaptured.

## Timing
- Synchronizer latency S: S = 2 with the synchronizer compiled in, S = 0 without it.
- Pin pair held from edge k: capture at edge k+S+ESTAVEL-1; commit and atualizado at the next edge.
- Last-digit latency to atualizado: S+ESTAVEL cycles.
- atualizado width: exactly 1 cycle.
- Commit spacing: ≥ NUM_DIG·ESTAVEL cycles.
- Simultaneous events:
  - If a pair change coincides with the commit cycle, the commit still happens and the new pair starts a new count.
  - If a capture that completes the mask falls on a commit cycle, it counts toward the next frame.

## Configuration
- CODIF_SINC_EN:
  - Defined: two-flop synchronizer on segmentos and anodos; S = 2. Use this for board pins.
  - Undefined: inputs are sampled directly; S = 0. Use this for on-chip connection to the decoder.
  - Reset value of the synchronizer flops: anodos all ones, segmentos all ones.

## Structure
- Shared package:
  - segment pattern constants for 0–F and blank;
  - FSM state encoding (OCIOSO/AMOSTRA/CAPTURADO).
- Sub-module seg_para_hex: combinational 7-bit → {nibble, blank, invalid}. It is the table inverse, instantiated once and fed the sampled segments.

## Test plan
- NUM_DIG=4, ESTAVEL=4, synchronizer compiled in. Hold digits 3..0 = 2,0,2,4 (0010010, 0000001, 0010010, 1001100), 8 cycles each → valor=16'h2024, apagado=0, erro=0, atualizado one pulse 6 cycles after the last digit's start.
- Digit 1 = 0110110 (invalid), others valid → erro=1, that nibble=0. Next clean frame → erro=0.
- Digit 2 = 1111111 → apagado=4'b0100, nibble 0.
- Glitch: segments change every 3 cycles on one digit → no capture and no atualizado. Value stable for 4 samples → captured.
- anodos=4'b0000 or 4'b1111 for 20 cycles → FSM OCIOSO, outputs unchanged.
- reset low mid-frame with 3 digits captured → all outputs 0 immediately. After release, a 4-digit scan is required before atualizado.
